// File: rtl/mux_arb_rr_pkg.sv
// Shared definitions for the registered C-channel mux/arbiter: mode encodings
// and the pointer reset value.
package mux_arb_rr_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   // Pointer resets to the last channel so the first round-robin search starts at channel 0.
   function automatic int ptr_reset(input int c);
      return c - 32'sd1;
   endfunction

endpackage

// File: rtl/mux_arb_rr_if.sv
// Producer/consumer bundle of the mux/arbiter; master drives requests and
// consumer ready, slave is the mux itself.
interface mux_arb_rr_if #(
   parameter int N  = 8,
   parameter int C  = 8,
   parameter int SW = $clog2(C)
);
   logic [C*N-1:0] in_data;
   logic [C-1:0]   in_valid;
   logic [C-1:0]   in_ready;
   logic           mode;
   logic [SW-1:0]  sel;
   logic [N-1:0]   out_data;
   logic [SW-1:0]  out_chan;
   logic           out_valid;
   logic           out_ready;

   modport master (
      output in_data, in_valid, mode, sel, out_ready,
      input  in_ready, out_data, out_chan, out_valid
   );

   modport slave (
      input  in_data, in_valid, mode, sel, out_ready,
      output in_ready, out_data, out_chan, out_valid
   );
endinterface

// File: rtl/mux_arb_rr_rr_pick.sv
// Combinational round-robin picker: rotates the request vector so the search
// starts just after ptr, priority-encodes, then un-rotates the winner.
module mux_arb_rr_rr_pick #(
   parameter int C  = 8,
   parameter int SW = $clog2(C)
) (
   input  logic [C-1:0]  req,
   input  logic [SW-1:0] ptr,
   output logic          grant_valid,
   output logic [SW-1:0] grant
);

   logic [C-1:0]  rot_s;
   logic [SW-1:0] first_s;

   // Rotate so that rot_s[0] is the channel right after ptr (modulo C).
   always_comb begin
      rot_s = '0;
      for (int i = 0; i < C; i++) begin
         rot_s[i] = req[SW'((int'(ptr) + 1 + i) % C)];
      end
   end

   // Lowest set bit of the rotated vector wins; scanning downward leaves the lowest.
   always_comb begin
      first_s = '0;
      for (int i = C - 1; i >= 0; i--) begin
         if (rot_s[i]) begin
            first_s = SW'(i);
         end else begin
            first_s = first_s;
         end
      end
   end

   // Undo the rotation to recover the absolute channel index.
   always_comb begin
      grant_valid = |rot_s;
      grant       = SW'((int'(ptr) + 1 + int'(first_s)) % C);
   end

endmodule

// File: rtl/mux_arb_rr.sv
// Registered C-channel multiplexer with valid/ready handshake, selectable
// between fixed (sel-steered) and round-robin arbitration.
import mux_arb_rr_pkg::*;

module mux_arb_rr #(
   parameter int N  = 8,
   parameter int C  = 8,
   parameter int SW = $clog2(C)
) (
   input  logic         clk,
   input  logic         rst_n,
   mux_arb_rr_if.slave  bus
);

   localparam logic [SW-1:0] PTR_RST = SW'(ptr_reset(C));

   logic [SW-1:0]     ptr_r;
   logic [N-1:0]      out_data_r;
   logic [SW-1:0]     out_chan_r;
   logic              out_valid_r;
   logic              rr_valid_s;
   logic [SW-1:0]     rr_grant_s;
   logic [2**SW-1:0]  valid_pad_s;
   logic              grant_valid_s;
   logic [SW-1:0]     grant_s;
   logic              load_s;
   logic              xfer_s;
   logic [C-1:0]      in_ready_s;
   logic [N-1:0]      data_sel_s;

   mux_arb_rr_rr_pick #(.C(C), .SW(SW)) u_pick (
      .req         (bus.in_valid),
      .ptr         (ptr_r),
      .grant_valid (rr_valid_s),
      .grant       (rr_grant_s)
   );

   // Grant source select; a sel beyond the last channel never grants.
   always_comb begin
      valid_pad_s          = '0;
      valid_pad_s[C-1:0]   = bus.in_valid;
      if (bus.mode == MODE_RR) begin
         grant_valid_s = rr_valid_s;
         grant_s       = rr_grant_s;
      end else begin
         grant_valid_s = (int'(bus.sel) < C) && valid_pad_s[bus.sel];
         grant_s       = bus.sel;
      end
      load_s = !out_valid_r || bus.out_ready;
      xfer_s = rst_n && load_s && grant_valid_s;
   end

   // One-hot ready decode and data mux for the granted channel.
   always_comb begin
      in_ready_s = '0;
      data_sel_s = '0;
      for (int k = 0; k < C; k++) begin
         if (int'(grant_s) == k) begin
            in_ready_s[k] = xfer_s;
            data_sel_s    = bus.in_data[k*N +: N];
         end else begin
            in_ready_s[k] = 1'b0;
         end
      end
   end

   // Single-entry output register and round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_r  <= '0;
         out_chan_r  <= '0;
         out_valid_r <= 1'b0;
         ptr_r       <= PTR_RST;
      end else begin
         if (xfer_s) begin
            out_data_r  <= data_sel_s;
            out_chan_r  <= grant_s;
            out_valid_r <= 1'b1;
         end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
         end else begin
            out_valid_r <= out_valid_r;
         end
         if (xfer_s && (bus.mode == MODE_RR)) begin
            ptr_r <= grant_s;
         end else begin
            ptr_r <= ptr_r;
         end
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.out_data  = out_data_r;
   assign bus.out_chan  = out_chan_r;
   assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_mux_arb_rr.sv
// Scoreboard bench for mux_arb_rr: an 8-channel and a 5-channel instance
// checked against a behavioural arbitration model.
module tb_mux_arb_rr;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mux_arb_rr_if #(.N(8), .C(8)) b8 ();
   mux_arb_rr_if #(.N(8), .C(5)) b5 ();

   mux_arb_rr #(.N(8), .C(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
   mux_arb_rr #(.N(8), .C(5)) u5 (.clk(clk), .rst_n(rst_n), .bus(b5.slave));

   int n_cmp = 0;
   int n_bad = 0;
   logic [10:0] q8[$];
   logic [10:0] q5[$];
   int mptr8 = 7;
   int mptr5 = 4;

   function automatic void model_grant(input int c, input logic md, input int s,
                                       input logic [15:0] v, input int p,
                                       output bit gv, output int g);
      gv = 1'b0;
      g  = 0;
      if (md) begin
         for (int i = 1; i <= c; i++) begin
            if (!gv && v[(p + i) % c]) begin
               gv = 1'b1;
               g  = (p + i) % c;
            end
         end
      end else if (s < c && v[s]) begin
         gv = 1'b1;
         g  = s;
      end
   endfunction

   task automatic cycle8(input string tag);
      logic [7:0] er;
      bit gv, ov;
      int g;
      #1;
      ov = (q8.size() != 0);
      n_cmp++;
      if (b8.out_valid !== ov) begin
         n_bad++; $display("FAIL %s c8 out_valid: got %b want %b", tag, b8.out_valid, ov);
      end
      if (ov) begin
         n_cmp++;
         if ({b8.out_chan, b8.out_data} !== q8[0]) begin
            n_bad++; $display("FAIL %s c8 chan/data: got %h want %h", tag, {b8.out_chan, b8.out_data}, q8[0]);
         end
         if (b8.out_ready) void'(q8.pop_front());
      end
      model_grant(8, b8.mode, int'(b8.sel), 16'(b8.in_valid), mptr8, gv, g);
      er = '0;
      if ((!ov || b8.out_ready) && gv) begin
         er[g] = 1'b1;
         q8.push_back({3'(g), b8.in_data[g*8 +: 8]});
         if (b8.mode) mptr8 = g;
      end
      n_cmp++;
      if (b8.in_ready !== er) begin
         n_bad++; $display("FAIL %s c8 in_ready: got %b want %b", tag, b8.in_ready, er);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic cycle5(input string tag);
      logic [4:0] er;
      bit gv, ov;
      int g;
      #1;
      ov = (q5.size() != 0);
      n_cmp++;
      if (b5.out_valid !== ov) begin
         n_bad++; $display("FAIL %s c5 out_valid: got %b want %b", tag, b5.out_valid, ov);
      end
      if (ov) begin
         n_cmp++;
         if ({b5.out_chan, b5.out_data} !== q5[0]) begin
            n_bad++; $display("FAIL %s c5 chan/data: got %h want %h", tag, {b5.out_chan, b5.out_data}, q5[0]);
         end
         if (b5.out_ready) void'(q5.pop_front());
      end
      model_grant(5, b5.mode, int'(b5.sel), 16'(b5.in_valid), mptr5, gv, g);
      er = '0;
      if ((!ov || b5.out_ready) && gv) begin
         er[g] = 1'b1;
         q5.push_back({3'(g), b5.in_data[g*8 +: 8]});
         if (b5.mode) mptr5 = g;
      end
      n_cmp++;
      if (b5.in_ready !== er) begin
         n_bad++; $display("FAIL %s c5 in_ready: got %b want %b", tag, b5.in_ready, er);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_data8();
      for (int k = 0; k < 8; k++) b8.in_data[k*8 +: 8] = 8'(8'h30 + k);
   endtask

   task automatic clear_model();
      q8.delete(); q5.delete();
      mptr8 = 7; mptr5 = 4;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      clear_model();
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      b8.mode = 1'b1; b8.sel = 3'd0; b8.in_valid = 8'hFF; b8.out_ready = 1'b1; set_data8();
      b5.mode = 1'b1; b5.sel = 3'd0; b5.in_valid = 5'h1F; b5.out_ready = 1'b1;
      for (int k = 0; k < 5; k++) b5.in_data[k*8 +: 8] = 8'(8'h50 + k);
      #3;
      n_cmp++;
      if (b8.in_ready !== 8'h00 || b5.in_ready !== 5'h00) begin
         n_bad++; $display("FAIL reset in_ready: got %b/%b want 0", b8.in_ready, b5.in_ready);
      end
      n_cmp++;
      if ({b8.out_valid, b8.out_chan, b8.out_data} !== 12'h000) begin
         n_bad++; $display("FAIL reset outputs: got %h want 000", {b8.out_valid, b8.out_chan, b8.out_data});
      end
      b8.in_valid = 8'h00; b5.in_valid = 5'h00;
      @(negedge clk);
      rst_n = 1'b1;
      clear_model();
   endtask

   task automatic test_rr_sweep();
      logic [7:0] exp_r;
      b8.mode = 1'b1; b8.in_valid = 8'hFF; b8.out_ready = 1'b1; set_data8();
      for (int i = 0; i < 10; i++) begin
         exp_r = 8'h01 << (i % 8);
         #1;
         n_cmp++;
         if (b8.in_ready !== exp_r) begin
            n_bad++; $display("FAIL rr_sweep grant %0d: got %b want %b", i, b8.in_ready, exp_r);
         end
         cycle8("rr_sweep");
      end
   endtask

   task automatic test_fixed();
      b8.mode = 1'b0; b8.sel = 3'd3; b8.in_valid = 8'b0000_1000; b8.in_data[24 +: 8] = 8'hA5;
      #1;
      n_cmp++;
      if (b8.in_ready !== 8'b0000_1000) begin
         n_bad++; $display("FAIL fixed in_ready: got %b want 00001000", b8.in_ready);
      end
      cycle8("fixed");
      b8.in_valid = 8'h00;
      cycle8("fixed");
      #1;
      n_cmp++;
      if ({b8.out_valid, b8.out_chan, b8.out_data} !== {1'b0, 3'd3, 8'hA5}) begin
         n_bad++; $display("FAIL fixed hold: got %h want %h", {b8.out_valid, b8.out_chan, b8.out_data}, {1'b0, 3'd3, 8'hA5});
      end
      @(negedge clk);
   endtask

   task automatic test_stall();
      b8.mode = 1'b1; b8.in_valid = 8'hFF; b8.out_ready = 1'b0; set_data8();
      cycle8("stall_load");
      for (int i = 0; i < 4; i++) begin
         #1;
         n_cmp++;
         if (b8.in_ready !== 8'h00 || b8.out_data !== 8'h32) begin
            n_bad++; $display("FAIL stall %0d: got ready %b data %h want 0/32", i, b8.in_ready, b8.out_data);
         end
         cycle8("stall");
      end
      b8.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle8("back_to_back");
      end
      b8.in_valid = 8'h00;
      cycle8("drain");
      cycle8("idle");
   endtask

   task automatic test_rr_pair();
      logic [7:0] seq [7];
      seq = '{8'h04, 8'h40, 8'h04, 8'h40, 8'h04, 8'h04, 8'h04};
      do_reset();
      b8.mode = 1'b1; b8.out_ready = 1'b1; set_data8();
      for (int i = 0; i < 7; i++) begin
         b8.in_valid = (i < 4) ? 8'h44 : 8'h04;
         #1;
         n_cmp++;
         if (b8.in_ready !== seq[i]) begin
            n_bad++; $display("FAIL rr_pair %0d: got %b want %b", i, b8.in_ready, seq[i]);
         end
         cycle8("rr_pair");
      end
      b8.in_valid = 8'h00;
      cycle8("rr_pair_drain");
   endtask

   task automatic test_c5_sel_range();
      b5.mode = 1'b1; b5.in_valid = 5'b00100; b5.out_ready = 1'b1;
      #1;
      n_cmp++;
      if (b5.in_ready !== 5'b00100) begin
         n_bad++; $display("FAIL c5 rr first: got %b want 00100", b5.in_ready);
      end
      cycle5("c5_rr");
      b5.mode = 1'b0; b5.sel = 3'd6; b5.in_valid = 5'h1F;
      cycle5("c5_sel6");
      #1;
      n_cmp++;
      if (b5.out_valid !== 1'b0 || b5.in_ready !== 5'h00) begin
         n_bad++; $display("FAIL c5 sel6 drained: got valid %b ready %b want 0/0", b5.out_valid, b5.in_ready);
      end
      cycle5("c5_sel6");
      b5.mode = 1'b1;
      #1;
      n_cmp++;
      if (b5.in_ready !== 5'b01000) begin
         n_bad++; $display("FAIL c5 rr resume: got %b want 01000", b5.in_ready);
      end
      cycle5("c5_resume");
      b5.in_valid = 5'h00;
      cycle5("c5_drain");
      cycle5("c5_idle");
   endtask

   task automatic test_async_reset();
      b8.mode = 1'b1; b8.in_valid = 8'hFF; b8.out_ready = 1'b1; set_data8();
      for (int i = 0; i < 3; i++) cycle8("pre_reset");
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (b8.out_valid !== 1'b0 || b8.in_ready !== 8'h00) begin
         n_bad++; $display("FAIL async reset: got valid %b ready %b want 0/0", b8.out_valid, b8.in_ready);
      end
      clear_model();
      @(negedge clk);
      rst_n = 1'b1;
      b8.in_valid = 8'b0011_0000;
      #1;
      n_cmp++;
      if (b8.in_ready !== 8'b0001_0000) begin
         n_bad++; $display("FAIL post reset grant: got %b want 00010000", b8.in_ready);
      end
      cycle8("post_reset");
      b8.in_valid = 8'h00;
      cycle8("post_reset_drain");
   endtask

   initial begin
      test_reset();
      test_rr_sweep();
      test_fixed();
      test_stall();
      test_rr_pair();
      test_c5_sel_range();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
